pll_lock_sequencer: RTL and testbench

- Drives the reset input of the on-chip clock wizard and supervises its `locked` output.
- Releases a clean, lock-qualified active-low reset (`rst_n_out`) to downstream logic only after lock has been stable for a programmable time.
- On lock timeout it re-pulses the PLL reset, up to a retry limit, then declares failure.
- On lock loss during operation it re-asserts `rst_n_out` and restarts the PLL.
- Sits beside the clock wizard instance, in the free-running `sys_clk` domain.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 124 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encodings and sizing helpers for the PLL lock sequencer.
// Debug readers decode state_o with these constants.
package pll_seq_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } pll_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous status inputs.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the clock wizard reset, qualifies its locked output and releases a
// lock-qualified active-low reset downstream; retries on timeout, fails terminally.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 100000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned CNT_W         = 8
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               rst_n_out,
   output logic               lock_fail,
   output logic [CNT_W-1:0]   retry_cnt,
   output logic [CNT_W-1:0]   lost_cnt,
   output logic [STATE_W-1:0] state_o
);

   localparam int unsigned CntW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

   localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
   localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);

   pll_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic [CNT_W-1:0] lost_q, lost_d;
   logic [CNT_W-1:0] retry_inc;
   logic             locked_s;

   sync_2ff u_lock_sync (
      .clk_i (sys_clk),
      .rst_i (sys_rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_PLL_RST;
         cnt_q   <= '0;
         retry_q <= '0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         lost_q  <= lost_d;
      end
   end

   assign retry_inc = (retry_q == '1) ? retry_q : retry_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == RstLast) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == LockLast) begin
               retry_d = retry_inc;
               cnt_d   = '0;
               state_d = (32'(retry_inc) >= MAX_RETRY) ? S_FAIL : S_PLL_RST;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         S_STABLE: begin
            // A dropout here is a glitch, not a timeout: retry count is untouched.
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
               state_d = S_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
               lost_d  = (lost_q == '1) ? lost_q : lost_q + CNT_W'(1);
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pll_rst   = (state_q == S_PLL_RST) || (state_q == S_FAIL);
      rst_n_out = (state_q == S_RUN);
      lock_fail = (state_q == S_FAIL);
      retry_cnt = retry_q;
      lost_cnt  = lost_q;
      state_o   = state_q;
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; edge numbers
// count from the first edge after sys_rst is released.
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   localparam int unsigned CntW = 2;

   logic                sys_clk = 1'b0;
   logic                sys_rst;
   logic                pll_locked;
   logic                pll_rst;
   logic                rst_n_out;
   logic                lock_fail;
   logic [CntW-1:0]     retry_cnt;
   logic [CntW-1:0]     lost_cnt;
   logic [STATE_W-1:0]  state_o;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   pll_lock_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRY     (3),
      .CNT_W         (CntW)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .rst_n_out  (rst_n_out),
      .lock_fail  (lock_fail),
      .retry_cnt  (retry_cnt),
      .lost_cnt   (lost_cnt),
      .state_o    (state_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input pll_state_e st, input logic prst,
                          input logic rstn, input logic fail, input int unsigned retry,
                          input int unsigned lost);
      chk({tag, ".state"}, 32'(state_o), 32'(st));
      chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(prst));
      chk({tag, ".rst_n_out"}, 32'(rst_n_out), 32'(rstn));
      chk({tag, ".lock_fail"}, 32'(lock_fail), 32'(fail));
      chk({tag, ".retry_cnt"}, 32'(retry_cnt), retry);
      chk({tag, ".lost_cnt"}, 32'(lost_cnt), lost);
   endtask

   // Advance to 1 time unit after edge t.
   task automatic to_edge(input int t);
      while (edge_n < t) begin
         @(posedge sys_clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic reset_cycle();
      sys_rst    = 1'b1;
      pll_locked = 1'b0;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic release_rst();
      sys_rst = 1'b0;
      edge_n  = -1;
   endtask

   initial begin
      sys_rst    = 1'b1;
      pll_locked = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk_all("reset", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, 0);

      // Nominal lock: locked sampled high at edge 10, release at edge 20.
      release_rst();
      to_edge(0);  chk_all("t1_e0", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, 0);
      to_edge(2);  chk("t1_e2.pll_rst", 32'(pll_rst), 32'd1);
      to_edge(3);  chk_all("t1_e3", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
      to_edge(9);  pll_locked = 1'b1;
      to_edge(11); chk("t1_e11.state", 32'(state_o), 32'(S_WAIT_LOCK));
      to_edge(12); chk("t1_e12.state", 32'(state_o), 32'(S_STABLE));
      to_edge(19); chk_all("t1_e19", S_STABLE, 1'b0, 1'b0, 1'b0, 0, 0);
      to_edge(20); chk_all("t1_e20", S_RUN, 1'b0, 1'b1, 1'b0, 0, 0);

      // Loss in RUN: locked sampled low at edge 23, relocked at edge 32.
      to_edge(22); pll_locked = 1'b0;
      to_edge(24); chk("t4_e24.rst_n_out", 32'(rst_n_out), 32'd1);
      to_edge(25); chk_all("t4_e25", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, 1);
      to_edge(28); chk("t4_e28.pll_rst", 32'(pll_rst), 32'd1);
      to_edge(29); chk_all("t4_e29", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 1);
      to_edge(31); pll_locked = 1'b1;
      to_edge(41); chk_all("t4_e41", S_STABLE, 1'b0, 1'b0, 1'b0, 0, 1);
      to_edge(42); chk_all("t4_e42", S_RUN, 1'b0, 1'b1, 1'b0, 0, 1);

      // Four more losses: lost_cnt saturates at 3 with a 2-bit counter.
      for (int i = 0; i < 4; i++) begin
         automatic int base = edge_n;
         automatic int unsigned exp_lost = (i == 0) ? 2 : 3;
         pll_locked = 1'b0;
         to_edge(base + 3);
         chk_all("t6_lost", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, exp_lost);
         pll_locked = 1'b1;
         to_edge(base + 15);
         chk("t6_stable.rst_n_out", 32'(rst_n_out), 32'd0);
         to_edge(base + 16);
         chk_all("t6_relock", S_RUN, 1'b0, 1'b1, 1'b0, 0, exp_lost);
      end

      // Glitch in STABLE: low sampled at edge 15 only.
      reset_cycle();
      chk_all("t2_reset", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, 0);
      release_rst();
      to_edge(9);  pll_locked = 1'b1;
      to_edge(12); chk("t2_e12.state", 32'(state_o), 32'(S_STABLE));
      to_edge(14); pll_locked = 1'b0;
      to_edge(15); pll_locked = 1'b1;
      to_edge(16); chk("t2_e16.state", 32'(state_o), 32'(S_STABLE));
      to_edge(17); chk_all("t2_e17", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
      to_edge(18); chk("t2_e18.state", 32'(state_o), 32'(S_STABLE));
      to_edge(25); chk("t2_e25.rst_n_out", 32'(rst_n_out), 32'd0);
      to_edge(26); chk_all("t2_e26", S_RUN, 1'b0, 1'b1, 1'b0, 0, 0);

      // Reset mid-STABLE, then the restarted sequence never locks.
      reset_cycle();
      release_rst();
      to_edge(9);  pll_locked = 1'b1;
      to_edge(13); chk("t5_e13.state", 32'(state_o), 32'(S_STABLE));
      reset_cycle();
      chk_all("t5_reset", S_PLL_RST, 1'b1, 1'b0, 1'b0, 0, 0);
      release_rst();
      to_edge(2);  chk("t5_e2.pll_rst", 32'(pll_rst), 32'd1);
      to_edge(3);  chk_all("t5_e3", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);

      to_edge(22); chk_all("t3_e22", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
      to_edge(23); chk_all("t3_e23", S_PLL_RST, 1'b1, 1'b0, 1'b0, 1, 0);
      to_edge(26); chk("t3_e26.pll_rst", 32'(pll_rst), 32'd1);
      to_edge(27); chk_all("t3_e27", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1, 0);
      to_edge(46); chk("t3_e46.state", 32'(state_o), 32'(S_WAIT_LOCK));
      to_edge(47); chk_all("t3_e47", S_PLL_RST, 1'b1, 1'b0, 1'b0, 2, 0);
      to_edge(51); chk_all("t3_e51", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 2, 0);
      to_edge(70); chk_all("t3_e70", S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 2, 0);
      to_edge(71); chk_all("t3_e71", S_FAIL, 1'b1, 1'b0, 1'b1, 3, 0);
      pll_locked = 1'b1;
      to_edge(90); chk_all("t3_e90", S_FAIL, 1'b1, 1'b0, 1'b1, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
